// File: rtl/display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// display_scan_ctrl
//   Time-multiplexed scan controller for a 4-digit status display.
//   Steps a 2-bit digit select through slots 0..3 and drives the matching
//   anode, blanking every anode for the first BLANK_CYCLES cycles of each
//   slot to suppress ghosting. The four digit codes are copied into a
//   frame-stable register set only when a new frame starts, so one frame
//   never mixes old and new values.
//
// Ports
//   clk_i         system clock
//   rst_ni        asynchronous active-low reset
//   enable_i      1 = scan, 0 = display off (counters cleared, data kept)
//   dig0_i..3_i   live 5-bit digit codes
//   control_o     current slot index, select for the downstream mux
//   mux_in0_o..3  latched frame copy of dig0_i..dig3_i
//   anode_o       one-hot digit enable, polarity set by ANODE_ACTIVE_LOW
//   frame_tick_o  one-cycle pulse on the edge a fresh frame is latched
// ---------------------------------------------------------------------------
module display_scan_ctrl #(
    parameter int REFRESH_DIV      = 100000,
    parameter int BLANK_CYCLES     = 1000,
    parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    input  logic [4:0] dig0_i,
    input  logic [4:0] dig1_i,
    input  logic [4:0] dig2_i,
    input  logic [4:0] dig3_i,
    output logic [1:0] control_o,
    output logic [4:0] mux_in0_o,
    output logic [4:0] mux_in1_o,
    output logic [4:0] mux_in2_o,
    output logic [4:0] mux_in3_o,
    output logic [3:0] anode_o,
    output logic       frame_tick_o
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    // Only consulted while in BLANK, which is unreachable when BLANK_CYCLES==0.
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [3:0] ANODE_OFF = ANODE_ACTIVE_LOW ? 4'b1111 : 4'b0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_e;

    // Every slot opens with a blank phase unless blanking is disabled.
    localparam state_e SLOT_START = (BLANK_CYCLES == 0) ? DRIVE : BLANK;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       control_q, control_d;
    logic [3:0]       anode_q, anode_d;
    logic             tick_q, tick_d;
    logic             latch;
    logic [4:0]       dig_w [4];
    logic [4:0]       mux_q [4];
    logic [3:0]       onehot;

    assign dig_w[0] = dig0_i;
    assign dig_w[1] = dig1_i;
    assign dig_w[2] = dig2_i;
    assign dig_w[3] = dig3_i;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        control_d = control_q;
        latch     = 1'b0;
        if (!enable_i) begin
            state_d   = IDLE;
            cnt_d     = '0;
            control_d = 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    latch     = 1'b1;
                    cnt_d     = '0;
                    control_d = 2'd0;
                    state_d   = SLOT_START;
                end
                BLANK, DRIVE: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d     = '0;
                        control_d = control_q + 2'd1;
                        state_d   = SLOT_START;
                        latch     = (control_q == 2'd3);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (state_q == BLANK && cnt_q == BLANK_LAST) begin
                            state_d = DRIVE;
                        end
                    end
                end
                default: begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    control_d = 2'd0;
                end
            endcase
        end
        tick_d = latch;
        // Anode is derived from the next state so it lines up with control_o.
        onehot  = 4'b0001 << control_d;
        anode_d = ANODE_OFF;
        if (state_d == DRIVE) begin
            anode_d = ANODE_ACTIVE_LOW ? ~onehot : onehot;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            control_q <= 2'd0;
            anode_q   <= ANODE_OFF;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            control_q <= control_d;
            anode_q   <= anode_d;
            tick_q    <= tick_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_frame_reg
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    mux_q[gi] <= 5'd0;
                end else if (latch) begin
                    mux_q[gi] <= dig_w[gi];
                end
            end
        end
    endgenerate

    assign control_o    = control_q;
    assign anode_o      = anode_q;
    assign frame_tick_o = tick_q;
    assign mux_in0_o    = mux_q[0];
    assign mux_in1_o    = mux_q[1];
    assign mux_in2_o    = mux_q[2];
    assign mux_in3_o    = mux_q[3];

endmodule
